// File: rtl/wb_regfile.sv
// Write-back select plus 32-entry register file with two bypassed read ports and a debug port.
// Latency: busW/busA/busB combinational; writes and wb_count commit on the next posedge.
// Backpressure: none, one write-back accepted every cycle.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] memory_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic [ADDR_W-1:0] Rw_in,
    input  logic              MemtoReg_in,
    input  logic              RegWr_in,
    input  logic [ADDR_W-1:0] Ra,
    input  logic [ADDR_W-1:0] Rb,
    output logic [DATA_W-1:0] busA,
    output logic [DATA_W-1:0] busB,
    output logic [DATA_W-1:0] busW,
    output logic [31:0]       wb_count,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [31:0]       cnt_q;
    logic              commit;
    logic              byp_a;
    logic              byp_b;

    assign busW   = MemtoReg_in ? memory_in : result_in;
    assign commit = RegWr_in && (Rw_in != '0) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            cnt_q <= '0;
        end else if (commit) begin
            regs[Rw_in] <= busW;
            cnt_q       <= cnt_q + 32'd1;
        end
    end

    assign wb_count = cnt_q;

    // Bypass is gated only by RegWr_in; index 0 is caught by the zero check below.
    assign byp_a = (BYPASS != 0) && RegWr_in && (Rw_in == Ra);
    assign byp_b = (BYPASS != 0) && RegWr_in && (Rw_in == Rb);

    always_comb begin
        busA = '0;
        busB = '0;
        if (Ra != '0) begin
            busA = byp_a ? busW : regs[Ra];
        end
        if (Rb != '0) begin
            busB = byp_b ? busW : regs[Rb];
        end
    end

    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: stimulus pushes expectations, a monitor pops and compares.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [31:0] memory_in;
    logic [31:0] result_in;
    logic [4:0]  Rw_in;
    logic        MemtoReg_in;
    logic        RegWr_in;
    logic [4:0]  Ra;
    logic [4:0]  Rb;
    logic [4:0]  dbg_addr;
    logic [31:0] busA, busB, busW, wb_count, dbg_data;
    logic [31:0] nb_busA, nb_busB, nb_busW, nb_wb_count, nb_dbg_data;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .memory_in(memory_in), .result_in(result_in),
        .Rw_in(Rw_in), .MemtoReg_in(MemtoReg_in), .RegWr_in(RegWr_in),
        .Ra(Ra), .Rb(Rb), .busA(busA), .busB(busB), .busW(busW),
        .wb_count(wb_count), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .memory_in(memory_in), .result_in(result_in),
        .Rw_in(Rw_in), .MemtoReg_in(MemtoReg_in), .RegWr_in(RegWr_in),
        .Ra(Ra), .Rb(Rb), .busA(nb_busA), .busB(nb_busB), .busW(nb_busW),
        .wb_count(nb_wb_count), .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output selectors carried with each expectation.
    localparam int S_A = 0, S_B = 1, S_W = 2, S_DBG = 3, S_CNT = 4, S_NBA = 5;

    int          sel_q  [$];
    logic [31:0] exp_q  [$];
    string       name_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    event        chk_evt;

    function automatic logic [31:0] observe(int s);
        case (s)
            S_A:     return busA;
            S_B:     return busB;
            S_W:     return busW;
            S_DBG:   return dbg_data;
            S_CNT:   return wb_count;
            default: return nb_busA;
        endcase
    endfunction

    initial begin
        forever begin
            @(chk_evt);
            while (sel_q.size() > 0) begin
                int          s;
                logic [31:0] e;
                logic [31:0] a;
                string       n;
                s = sel_q.pop_front();
                e = exp_q.pop_front();
                n = name_q.pop_front();
                a = observe(s);
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", n, a, e);
                end
            end
        end
    end

    task automatic expect_v(input int s, input logic [31:0] e, input string n);
        sel_q.push_back(s);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic check_now();
        ->chk_evt;
        #0;
    endtask

    // Inputs change on negedge, as the MEM/WB register does.
    task automatic drive(input logic we, input logic [4:0] rw, input logic m2r,
                         input logic [31:0] res, input logic [31:0] mem);
        @(negedge clk);
        RegWr_in    = we;
        Rw_in       = rw;
        MemtoReg_in = m2r;
        result_in   = res;
        memory_in   = mem;
        #2;
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; RegWr_in = 1'b0; Rw_in = '0; MemtoReg_in = 1'b0;
        result_in = '0; memory_in = '0; Ra = 5'd1; Rb = 5'd17; dbg_addr = 5'd31;

        repeat (2) @(posedge clk);
        #1;
        expect_v(S_A,   32'h0, "rst_busA_r1");
        expect_v(S_B,   32'h0, "rst_busB_r17");
        expect_v(S_DBG, 32'h0, "rst_dbg_r31");
        expect_v(S_CNT, 32'h0, "rst_count");
        check_now();
        dbg_addr = 5'd1; Ra = 5'd31; #1;
        expect_v(S_DBG, 32'h0, "rst_dbg_r1");
        expect_v(S_A,   32'h0, "rst_busA_r31");
        check_now();

        // Write coincident with reset is dropped; busW still tracks inputs.
        Ra = 5'd0; Rb = 5'd0; dbg_addr = 5'd3;
        drive(1'b1, 5'd3, 1'b0, 32'hAA, 32'h0);
        expect_v(S_W, 32'hAA, "busW_during_rst");
        check_now();
        post_edge();
        expect_v(S_DBG, 32'h0, "rst_collision_r3");
        expect_v(S_CNT, 32'h0, "rst_collision_count");
        check_now();

        @(negedge clk);
        rst = 1'b0;
        post_edge();
        expect_v(S_DBG, 32'hAA, "first_write_after_rst");
        expect_v(S_CNT, 32'h1,  "count_after_first");
        check_now();

        // Write-back select.
        dbg_addr = 5'd5;
        drive(1'b1, 5'd5, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF);
        expect_v(S_W, 32'h1234_5678, "busW_sel_result");
        check_now();
        post_edge();
        expect_v(S_DBG, 32'h1234_5678, "r5_result");
        expect_v(S_CNT, 32'h2, "count_2");
        check_now();
        drive(1'b1, 5'd5, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF);
        expect_v(S_W, 32'hDEAD_BEEF, "busW_sel_mem");
        check_now();
        post_edge();
        expect_v(S_DBG, 32'hDEAD_BEEF, "r5_mem");
        expect_v(S_CNT, 32'h3, "count_3");
        check_now();

        // Register 0 stays zero and is not counted.
        Ra = 5'd0; dbg_addr = 5'd0;
        drive(1'b1, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'h0);
        expect_v(S_A,   32'h0, "r0_busA_pre");
        expect_v(S_DBG, 32'h0, "r0_dbg_pre");
        check_now();
        post_edge();
        expect_v(S_A,   32'h0, "r0_busA_post");
        expect_v(S_DBG, 32'h0, "r0_dbg_post");
        expect_v(S_CNT, 32'h3, "r0_count_unchanged");
        check_now();

        // Bypass on r9: old value 0x11, new 0x22.
        drive(1'b1, 5'd9, 1'b0, 32'h11, 32'h0);
        post_edge();
        expect_v(S_CNT, 32'h4, "count_4");
        check_now();
        Ra = 5'd9; Rb = 5'd9; dbg_addr = 5'd9;
        drive(1'b1, 5'd9, 1'b0, 32'h22, 32'h0);
        expect_v(S_A,   32'h22, "bypass_busA_pre");
        expect_v(S_B,   32'h22, "bypass_busB_pre");
        expect_v(S_DBG, 32'h11, "bypass_dbg_pre");
        expect_v(S_NBA, 32'h11, "nobypass_busA_pre");
        check_now();
        post_edge();
        expect_v(S_A,   32'h22, "bypass_busA_post");
        expect_v(S_B,   32'h22, "bypass_busB_post");
        expect_v(S_DBG, 32'h22, "bypass_dbg_post");
        expect_v(S_NBA, 32'h22, "nobypass_busA_post");
        expect_v(S_CNT, 32'h5,  "count_5");
        check_now();

        // RegWr=0: no bypass, no write, no count.
        drive(1'b0, 5'd9, 1'b1, 32'h33, 32'h44);
        expect_v(S_A, 32'h22, "nowr_busA_pre");
        check_now();
        post_edge();
        expect_v(S_DBG, 32'h22, "nowr_dbg_post");
        expect_v(S_CNT, 32'h5,  "nowr_count");
        check_now();

        // Counter wrap via preload.
        @(negedge clk);
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        #1;
        expect_v(S_CNT, 32'hFFFF_FFFE, "count_preload");
        check_now();
        dbg_addr = 5'd7;
        drive(1'b1, 5'd7, 1'b0, 32'h77, 32'h0);
        post_edge();
        expect_v(S_CNT, 32'hFFFF_FFFF, "count_max");
        check_now();
        drive(1'b1, 5'd7, 1'b0, 32'h78, 32'h0);
        post_edge();
        expect_v(S_CNT, 32'h0,  "count_wrap");
        expect_v(S_DBG, 32'h78, "r7_after_wrap");
        check_now();

        drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
        #1;
        if (sel_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sel_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage plus the 32-entry general-purpose register file of the 5-stage pipeline.
- Sits directly downstream of the MEM/WB pipeline register and consumes its outputs: memory data, ALU result, destination register, MemtoReg and RegWr.
- Selects the write-back value, commits it to the register file, and serves the two ID-stage read ports with same-cycle write-through bypass.
- Also keeps a committed-write counter and a debug read port for the test bench.

Parameters:
- DATA_W, 32, register and bus width.
- ADDR_W, 5, register index width (2**ADDR_W entries).
- BYPASS, 1, 1 = write-through bypass on read ports; 0 = read only the stored value.

Ports:
- clk  in  1  clock; register file and counter update on posedge.
- rst  in  1  reset, synchronous, active-high.
- memory_in  in  DATA_W  load data from the MEM/WB register.
- result_in  in  DATA_W  ALU result from the MEM/WB register.
- Rw_in  in  ADDR_W  destination register index.
- MemtoReg_in  in  1  1 = write memory_in; 0 = write result_in.
- RegWr_in  in  1  register write enable.
- Ra  in  ADDR_W  read port A index (ID stage).
- Rb  in  ADDR_W  read port B index (ID stage).
- busA  out  DATA_W  read port A data, combinational.
- busB  out  DATA_W  read port B data, combinational.
- busW  out  DATA_W  selected write-back value, combinational.
- wb_count  out  32  number of committed register writes.
- dbg_addr  in  ADDR_W  debug read index.
- dbg_data  out  DATA_W  debug read data, stored value only, never bypassed.

Behaviour:
- Reset: rst is synchronous, active-high. On a posedge with rst=1:
  - all entries are cleared to 0;
  - wb_count is cleared to 0;
  - rst overrides any simultaneous write and any count increment.
- Outputs after reset:
  - busA, busB and dbg_data read 0 for every index;
  - busW stays combinational and tracks its inputs even while rst is high.
- Write-back select: busW = MemtoReg_in ? memory_in : result_in. Pure combinational, zero latency.
- Commit condition: commit = RegWr_in && (Rw_in != 0) && !rst.
  - On a posedge with commit, entry[Rw_in] takes busW.
  - The new value is visible through dbg_data and the non-bypassed read paths from that edge on.
- Register 0:
  - hardwired to 0; a write to it is discarded;
  - any read of index 0 (Ra, Rb or dbg_addr) returns 0, regardless of bypass;
  - a write to it does not increment wb_count.
- Read ports:
  - busA = 0 if Ra == 0.
  - Otherwise, when BYPASS=1 and RegWr_in && Rw_in == Ra, busA = busW (write-through, same cycle).
  - Otherwise busA = entry[Ra].
  - busB behaves identically using Rb.
  - Ra == Rb is legal; both ports return the same value.
  - With BYPASS=0, a same-cycle write is seen only after the commit edge.
- Timing: the MEM/WB register updates on negedge, so write-back inputs are stable for half a cycle before the commit posedge.
- wb_count: increments by 1 on every commit edge. Wraps from 0xFFFFFFFF to 0x00000000 with no flag.
- No stall, handshake or backpressure: one write-back per cycle, always accepted.
- Reset mid-stream: a write presented on the same edge as rst is lost. The write on the first edge after rst drops commits normally.
- X handling: Rw_in, MemtoReg_in and the data inputs are don't-care when RegWr_in=0. Nothing is written or counted in that case.

Test Plan:
- Reset check: assert rst for 2 cycles -> busA, busB and dbg_data read 0 for Ra, Rb, dbg_addr = 1, 17, 31; wb_count = 0.
- Write-back select:
  - RegWr=1, Rw=5, MemtoReg=0, result_in=0x1234_5678, memory_in=0xDEAD_BEEF -> after posedge, dbg_addr=5 reads 0x1234_5678.
  - Repeat with MemtoReg=1 -> reads 0xDEAD_BEEF; wb_count = 2.
- Register 0: RegWr=1, Rw=0, result_in=0xFFFF_FFFF -> dbg_addr=0 reads 0 and Ra=0 gives busA=0 (both before and after the edge); wb_count unchanged.
- Bypass: entry 9 holds 0x11; drive RegWr=1, Rw=9, result_in=0x22 with Ra=Rb=9 ->
  - before the posedge: busA = busB = 0x22 and dbg_data = 0x11;
  - after the posedge: all three read 0x22;
  - with BYPASS=0, busA reads 0x11 until the posedge.
- Reset collision: RegWr=1, Rw=3, result_in=0xAA together with rst=1 on the same edge -> entry 3 = 0 and wb_count = 0. A write of 0xAA the next cycle with rst=0 -> entry 3 = 0xAA and wb_count = 1.
- Counter wrap: force 0xFFFF_FFFE commits (or preload via a hierarchical force), then 2 more writes to r7 -> wb_count reads 0xFFFF_FFFF, then 0x0000_0000.
